// File: rtl/instmem_loader_if.sv
// ---------------------------------------------------------------------------
// instmem_loader_if
// Groups the host command, the instruction-word stream, the instruction
// memory write port and the status outputs of the program loader.
//
//   load_start/load_base/load_count : host load command
//   in_valid/in_data/in_ready       : instruction word stream (valid/ready)
//   mem_we/mem_addr/mem_wdata       : instruction memory write port
//   core_hold/busy/done             : core reset hold and load status
//   range_err/checksum              : command rejection pulse, word checksum
//
// master : the host side (drives commands and words, observes status)
// slave  : the loader side
// ---------------------------------------------------------------------------
interface instmem_loader_if #(
  parameter int INST_LENGTH = 8,
  parameter int ADDR_WIDTH  = 6
) ();

  logic                   load_start;
  logic [ADDR_WIDTH-1:0]  load_base;
  logic [ADDR_WIDTH:0]    load_count;
  logic                   in_valid;
  logic [INST_LENGTH-1:0] in_data;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INST_LENGTH-1:0] mem_wdata;
  logic                   core_hold;
  logic                   busy;
  logic                   done;
  logic                   range_err;
  logic [INST_LENGTH-1:0] checksum;

  modport master (
    output load_start, load_base, load_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  core_hold, busy, done, range_err, checksum
  );

  modport slave (
    input  load_start, load_base, load_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output core_hold, busy, done, range_err, checksum
  );

endinterface

// File: rtl/instmem_loader.sv
// ---------------------------------------------------------------------------
// instmem_loader
// Host-side program loader. Accepts a load command (base, count), then
// consumes instruction words from a valid/ready stream and issues one
// registered instruction-memory write per accepted word. The GPU core is
// held in reset for the whole load so it never fetches a partial program.
// Reports a completion pulse, a running modulo checksum of the loaded
// words and a pulse for commands that would run past the end of memory.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instmem_loader_if slave modport (command, stream, memory
//           write port, status)
// ---------------------------------------------------------------------------
module instmem_loader #(
  parameter int INST_LENGTH = 8,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  instmem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Memory depth expressed at ADDR_WIDTH+2 bits so the range check
  // base+count cannot wrap.
  localparam logic [ADDR_WIDTH+1:0] MEM_DEPTH = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);

  state_t                 state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
  logic [ADDR_WIDTH:0]    remain_q,   remain_d;
  logic                   memWe_q,    memWe_d;
  logic [ADDR_WIDTH-1:0]  memAddr_q,  memAddr_d;
  logic [INST_LENGTH-1:0] memWdata_q, memWdata_d;
  logic [INST_LENGTH-1:0] checksum_q, checksum_d;
  logic                   rangeErr_q, rangeErr_d;

  logic [ADDR_WIDTH+1:0]  endAddr;

  assign endAddr = {2'b00, bus.load_base} + {1'b0, bus.load_count};

  // State register and registered write port / status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      checksum_q <= '0;
      rangeErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      checksum_q <= checksum_d;
      rangeErr_q <= rangeErr_d;
    end
  end

  // Next-state logic. Commands are only looked at in IDLE and words are
  // only consumed in LOAD, so stray strobes elsewhere are dropped silently.
  // The write port fields hold their last value between writes; only
  // mem_we qualifies them.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    checksum_d = checksum_q;
    rangeErr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          if (endAddr > MEM_DEPTH) begin
            // Rejected command leaves the previous checksum visible.
            rangeErr_d = 1'b1;
          end else if (bus.load_count == '0) begin
            checksum_d = '0;
            state_d    = DONE;
          end else begin
            addr_d     = bus.load_base;
            remain_d   = bus.load_count;
            checksum_d = '0;
            state_d    = LOAD;
          end
        end
      end

      LOAD: begin
        if (bus.in_valid) begin
          memWe_d    = 1'b1;
          memAddr_d  = addr_q;
          memWdata_d = bus.in_data;
          addr_d     = addr_q + ADDR_ONE;
          remain_d   = remain_q - REM_ONE;
          checksum_d = checksum_q + bus.in_data;
          if (remain_q == REM_ONE) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are plain decodes of the state register.
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.core_hold = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.range_err = rangeErr_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_instmem_loader.sv
// ---------------------------------------------------------------------------
// tb_instmem_loader
// Drives load commands and randomized word streams into instmem_loader,
// keeps a behavioural instruction memory on the write port, and checks
// writes, status windows, checksum and memory contents against a
// reference model computed from the load rules.
// ---------------------------------------------------------------------------
module tb_instmem_loader;

  localparam int IL    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int LOGN  = 4096;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  instmem_loader_if #(.INST_LENGTH(IL), .ADDR_WIDTH(AW)) bus ();

  instmem_loader #(.INST_LENGTH(IL), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int expChecksum = 0;

  wr_t obsQ[$];
  int  wordQ[$];
  bit  validPat[$];

  logic [IL-1:0] imem [DEPTH];
  int  expMem [DEPTH];

  bit logBusy  [LOGN];
  bit logHold  [LOGN];
  bit logReady [LOGN];
  bit logDone  [LOGN];
  bit logRerr  [LOGN];

  // Cycle counter: a value read at a falling edge names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural instruction memory on the loader's write port.
  always @(posedge clk) begin
    if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logBusy[cyc % LOGN]  = bus.busy;
    logHold[cyc % LOGN]  = bus.core_hold;
    logReady[cyc % LOGN] = bus.in_ready;
    logDone[cyc % LOGN]  = bus.done;
    logRerr[cyc % LOGN]  = bus.range_err;
    if (bus.mem_we) obsQ.push_back('{int'(bus.mem_addr), int'(bus.mem_wdata), cyc});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".in_ready"},  int'(bus.in_ready),  0);
    checkOutput({tag, ".mem_we"},    int'(bus.mem_we),    0);
    checkOutput({tag, ".core_hold"}, int'(bus.core_hold), 0);
    checkOutput({tag, ".busy"},      int'(bus.busy),      0);
    checkOutput({tag, ".done"},      int'(bus.done),      0);
    checkOutput({tag, ".range_err"}, int'(bus.range_err), 0);
    checkOutput({tag, ".mem_addr"},  int'(bus.mem_addr),  0);
    checkOutput({tag, ".mem_wdata"}, int'(bus.mem_wdata), 0);
    checkOutput({tag, ".checksum"},  int'(bus.checksum),  0);
  endtask

  // Issues a command in the current cycle; returns that cycle's number.
  task automatic issueCommand(input int base, input int count, output int cmdCyc);
    bus.load_start = 1'b1;
    bus.load_base  = AW'(base);
    bus.load_count = (AW+1)'(count);
    bus.in_valid   = 1'b0;
    @(negedge clk);
    cmdCyc = cyc;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  // One complete load: command, word stream, trailing ignored words, then
  // all checks against the reference expectations.
  task automatic applyStimulus(input int base, input int count, input int validPct,
                               input bit interject);
    int  cmdCyc, lastHs, doneCyc, hs, budget, obsStart, sum, endCyc, pi, w, nObs;
    bit  isErr, v;
    bit  expBusy, expReady;
    int  words[$];
    int  hsCyc[$];

    isErr    = (base + count) > DEPTH;
    obsStart = obsQ.size();
    issueCommand(base, count, cmdCyc);

    hs = 0; sum = 0; pi = 0; budget = 400; lastHs = cmdCyc;
    if (!isErr) begin
      while (hs < count && budget > 0) begin
        if (validPat.size() > 0) v = validPat[pi % validPat.size()];
        else                     v = ($urandom_range(99) < validPct);
        pi++;
        w = (wordQ.size() > 0) ? wordQ[0] : int'($urandom_range(255));
        bus.in_valid = v;
        bus.in_data  = IL'(w);
        if (interject && hs == 1) begin
          bus.load_start = 1'b1;
          bus.load_base  = '0;
          bus.load_count = (AW+1)'(1);
        end
        @(negedge clk);
        if (v && bus.in_ready) begin
          if (wordQ.size() > 0) void'(wordQ.pop_front());
          words.push_back(w);
          hsCyc.push_back(cyc);
          sum += w;
          lastHs = cyc;
          hs++;
        end
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        budget--;
      end
      if (count > 0) checkOutput("handshakeBudget", hs, count);
    end

    // Words offered after the load must be ignored.
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IL'($urandom_range(255));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    endCyc = cyc - 1;

    if (isErr)           doneCyc = -1;
    else if (count == 0) doneCyc = cmdCyc + 1;
    else                 doneCyc = lastHs + 1;

    for (int c = cmdCyc; c <= endCyc; c++) begin
      expBusy  = !isErr && c >= cmdCyc + 1 && c <= doneCyc;
      expReady = !isErr && count > 0 && c >= cmdCyc + 1 && c <= lastHs;
      checkOutput($sformatf("busy@%0d", c),      int'(logBusy[c % LOGN]),  int'(expBusy));
      checkOutput($sformatf("core_hold@%0d", c), int'(logHold[c % LOGN]),  int'(expBusy));
      checkOutput($sformatf("in_ready@%0d", c),  int'(logReady[c % LOGN]), int'(expReady));
      checkOutput($sformatf("done@%0d", c),      int'(logDone[c % LOGN]),  int'(c == doneCyc));
      checkOutput($sformatf("range_err@%0d", c), int'(logRerr[c % LOGN]),
                  int'(isErr && c == cmdCyc + 1));
    end

    nObs = obsQ.size() - obsStart;
    checkOutput($sformatf("writeCount base=%0d count=%0d", base, count), nObs, isErr ? 0 : count);
    for (int i = 0; i < nObs && i < words.size(); i++) begin
      checkOutput($sformatf("writeAddr[%0d]", i), obsQ[obsStart+i].addr, base + i);
      checkOutput($sformatf("writeData[%0d]", i), obsQ[obsStart+i].data, words[i]);
      checkOutput($sformatf("writeCycle[%0d]", i), obsQ[obsStart+i].cyc, hsCyc[i] + 1);
    end

    if (!isErr) begin
      expChecksum = sum % 256;
      for (int i = 0; i < count; i++) expMem[base + i] = words[i];
      for (int i = 0; i < count; i++)
        checkOutput($sformatf("imem[%0d]", base + i), int'(imem[base + i]), expMem[base + i]);
    end
    checkOutput("checksum", int'(bus.checksum), expChecksum);
  endtask

  // Reset pulled low after two of five words have been written.
  task automatic resetMidLoad();
    int cmdCyc, hs, budget, obsStart, w;
    int words[$];

    obsStart = obsQ.size();
    issueCommand(10, 5, cmdCyc);
    hs = 0; budget = 20;
    while (hs < 2 && budget > 0) begin
      w = int'($urandom_range(255));
      bus.in_valid = 1'b1;
      bus.in_data  = IL'(w);
      @(negedge clk);
      if (bus.in_ready) begin
        words.push_back(w);
        hs++;
      end
      @(posedge clk); #1;
      budget--;
    end
    checkOutput("rst.handshakes", hs, 2);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.busyBefore", int'(bus.busy), 1);

    #2 rst_n = 1'b0;
    #1 checkResetValues("rstAsync");

    bus.in_valid   = 1'b1;
    bus.load_start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.in_valid   = 1'b0;
    bus.load_start = 1'b0;
    rst_n = 1'b1;
    checkResetValues("rstRelease");

    checkOutput("rst.writeCount", obsQ.size() - obsStart, 2);
    for (int i = 0; i < 2 && i < words.size(); i++) begin
      expMem[10 + i] = words[i];
      checkOutput($sformatf("rst.imem[%0d]", 10 + i), int'(imem[10 + i]), expMem[10 + i]);
    end
    expChecksum = 0;
  endtask

  initial begin
    int b, n;
    for (int i = 0; i < DEPTH; i++) expMem[i] = 0;
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    #1 checkResetValues("init");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] base 0, count 4, back to back");
    wordQ = '{'h11, 'h22, 'h33, 'h44};
    applyStimulus(0, 4, 100, 1'b0);
    checkOutput("checksumAA", int'(bus.checksum), 'hAA);

    $display("[TB] base 60, count 4, toggling valid");
    validPat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(60, 4, 0, 1'b0);
    validPat.delete();

    $display("[TB] range error, then full-memory load");
    applyStimulus(61, 4, 100, 1'b0);
    applyStimulus(0, 64, 70, 1'b0);

    $display("[TB] zero count, then command during load");
    applyStimulus(5, 0, 100, 1'b0);
    applyStimulus(20, 6, 60, 1'b1);

    $display("[TB] reset during load");
    resetMidLoad();
    applyStimulus(30, 5, 80, 1'b0);

    $display("[TB] checksum wrap");
    wordQ = '{'hFF, 'h02};
    applyStimulus(40, 2, 100, 1'b0);
    checkOutput("checksumWrap", int'(bus.checksum), 'h01);

    $display("[TB] random commands");
    for (int r = 0; r < 10; r++) begin
      b = int'($urandom_range(63));
      if ($urandom_range(1) == 0) n = int'($urandom_range(64 - b));
      else                        n = int'($urandom_range(64));
      applyStimulus(b, n, int'($urandom_range(30, 100)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
